spi_master_if: RTL and testbench

Single-clock SPI initiator that issues the 11-bit command frames consumed by `spi_wrapper` (SPI slave + RAM). Accepts one frame per valid/ready handshake from a host-side controller, serialises it MSB-first on `MOSI` under `SS_n`, and for read-data frames captures the 8-bit reply from `MISO` and returns it with a one-cycle strobe. Sits between the host/command sequencer and the `spi_wrapper` pins.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_cmd_if.sv | 24 ++
 rtl/spi_m_shifter.sv | 47 ++++
 rtl/spi_master_if.sv | 134 +++++++++++++
 tb/tb_spi_master_if.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants, command codes and FSM state type for the SPI command initiator.
package spi_pkg;

  localparam int unsigned FRAME_W = 11;
  localparam int unsigned DATA_W  = 8;

  // Frame bits [10:8].
  localparam logic [2:0] CMD_WR_ADDR = 3'b000;
  localparam logic [2:0] CMD_WR_DATA = 3'b001;
  localparam logic [2:0] CMD_RD_ADDR = 3'b110;
  localparam logic [2:0] CMD_RD_DATA = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StWait,
    StCapture,
    StGap
  } spi_m_state_e;

endpackage

// File: rtl/spi_cmd_if.sv
// Host-side command/response bundle of the SPI initiator.
interface spi_cmd_if;
  import spi_pkg::*;

  logic [FRAME_W-1:0] cmd_data;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_valid;
  logic               busy;

  // Host / sequencer side.
  modport master (
    output cmd_data, cmd_valid,
    input  cmd_ready, rd_data, rd_valid, busy
  );

  // SPI initiator side.
  modport slave (
    input  cmd_data, cmd_valid,
    output cmd_ready, rd_data, rd_valid, busy
  );

endinterface

// File: rtl/spi_m_shifter.sv
// MSB-first shift register with bit counter, shared by MOSI serialisation and MISO capture.
module spi_m_shifter
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               shift,
  input  logic               shift_in,
  input  logic               clr,
  input  logic               wide,      // 1: 11-bit frame, 0: 8-bit capture
  output logic               msb,
  output logic [DATA_W-1:0]  capt,      // low byte as it will be after this shift
  output logic               done
);

  localparam logic [3:0] LastWide   = 4'(FRAME_W - 1);
  localparam logic [3:0] LastNarrow = 4'(DATA_W - 1);

  logic [FRAME_W-1:0] data_q;
  logic [3:0]         cnt_q;

  // Data register and bit counter; load wins over shift, clr/load restart the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (load) begin
        data_q <= load_data;
      end else if (shift) begin
        data_q <= {data_q[FRAME_W-2:0], shift_in};
      end
      if (load || clr) begin
        cnt_q <= '0;
      end else if (shift) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign msb  = data_q[FRAME_W-1];
  assign capt = {data_q[DATA_W-2:0], shift_in};
  assign done = (cnt_q == (wide ? LastWide : LastNarrow));

endmodule

// File: rtl/spi_master_if.sv
// SPI initiator: sends 11-bit command frames and captures the 8-bit read-data reply.
module spi_master_if
  import spi_pkg::*;
#(
  parameter int unsigned RD_WAIT = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  spi_cmd_if.slave  cmd,
  output logic      MOSI,
  output logic      SS_n,
  input  logic      MISO
);

  localparam int unsigned WaitLastInt = (RD_WAIT > 0) ? RD_WAIT - 1 : 0;
  localparam logic [3:0]  WaitLast    = WaitLastInt[3:0];

  spi_m_state_e      state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic              is_rd_q, is_rd_d;
  logic              ss_n_q, ss_n_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ready;

  logic              sh_load, sh_shift, sh_in, sh_clr, sh_wide;
  logic              sh_msb, sh_done;
  logic [DATA_W-1:0] sh_capt;

  assign ready   = rst_n && (state_q == StIdle);
  assign sh_wide = (state_q != StCapture);

  spi_m_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .load_data (cmd.cmd_data),
    .shift     (sh_shift),
    .shift_in  (sh_in),
    .clr       (sh_clr),
    .wide      (sh_wide),
    .msb       (sh_msb),
    .capt      (sh_capt),
    .done      (sh_done)
  );

  // Next-state logic, shifter control and output register next values.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    is_rd_d    = is_rd_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_in      = 1'b0;
    sh_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd.cmd_valid && ready) begin
          sh_load = 1'b1;
          is_rd_d = (cmd.cmd_data[FRAME_W-1 -: 3] == CMD_RD_DATA);
          state_d = StShift;
        end
      end
      StShift: begin
        sh_shift = 1'b1;
        if (sh_done) begin
          sh_clr = 1'b1;
          wait_d = '0;
          if (!is_rd_q) begin
            state_d = StGap;
          end else if (RD_WAIT == 0) begin
            state_d = StCapture;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          state_d = StCapture;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StCapture: begin
        sh_shift = 1'b1;
        sh_in    = MISO;
        if (sh_done) begin
          rd_data_d  = sh_capt;
          rd_valid_d = 1'b1;
          state_d    = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    ss_n_d = !(state_d inside {StShift, StWait, StCapture});
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      is_rd_q    <= 1'b0;
      ss_n_q     <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      is_rd_q    <= is_rd_d;
      ss_n_q     <= ss_n_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // The shifter MSB is a flop and is zero outside SHIFT: the 11th shift empties the
  // frame, and the 8-bit capture never reaches bit 10.
  assign MOSI          = sh_msb;
  assign SS_n          = ss_n_q;
  assign cmd.cmd_ready = ready;
  assign cmd.rd_data   = rd_data_q;
  assign cmd.rd_valid  = rd_valid_q;
  assign cmd.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_master_if.sv
// Directed self-checking bench for spi_master_if (RD_WAIT=2 and RD_WAIT=0 instances).
module tb_spi_master_if;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic mosi_a, ss_n_a, miso_a;
  logic mosi_b, ss_n_b, miso_b;

  int n_cmp  = 0;
  int n_fail = 0;

  int ss_low_a = 0, rv_a = 0, hs_a = 0;
  int ss_low_b = 0, rv_b = 0;

  spi_cmd_if if_a ();
  spi_cmd_if if_b ();

  spi_master_if #(.RD_WAIT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (if_a.slave),
    .MOSI  (mosi_a),
    .SS_n  (ss_n_a),
    .MISO  (miso_a)
  );

  spi_master_if #(.RD_WAIT(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (if_b.slave),
    .MOSI  (mosi_b),
    .SS_n  (ss_n_b),
    .MISO  (miso_b)
  );

  always #5 clk = ~clk;

  // Mid-cycle event counters: SS_n-low cycles, rd_valid cycles, handshakes.
  always @(negedge clk) begin
    if (ss_n_a === 1'b0) ss_low_a++;
    if (if_a.rd_valid === 1'b1) rv_a++;
    if (if_a.cmd_valid === 1'b1 && if_a.cmd_ready === 1'b1) hs_a++;
    if (ss_n_b === 1'b0) ss_low_b++;
    if (if_b.rd_valid === 1'b1) rv_b++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_a.cmd_valid = 1'b1;
    if_a.cmd_data  = 11'h7FF;
    if_b.cmd_valid = 1'b0;
    if_b.cmd_data  = '0;
    miso_a = 1'b0;
    miso_b = 1'b0;
    repeat (3) tick();
    n_cmp++; if (ss_n_a !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n: got %b want 1", ss_n_a); end
    n_cmp++; if (mosi_a !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi_a); end
    n_cmp++; if (if_a.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", if_a.rd_valid); end
    n_cmp++; if (if_a.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", if_a.cmd_ready); end
    n_cmp++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if_a.busy); end
    n_cmp++; if (if_a.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", if_a.rd_data); end
    n_cmp++; if (ss_n_b !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n_b: got %b want 1", ss_n_b); end
    if_a.cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (if_a.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_cmd_ready: got %b want 1", if_a.cmd_ready); end
    n_cmp++; if (ss_n_a !== 1'b1) begin n_fail++; $display("FAIL post_reset_ss_n: got %b want 1", ss_n_a); end
  endtask

  task automatic test_write_addr();
    int exp_bits [11] = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1};
    int rv0 = rv_a;
    int ss0 = ss_low_a;
    n_cmp++; if (if_a.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_before: got %b want 1", if_a.cmd_ready); end
    if_a.cmd_data  = {CMD_WR_ADDR, 8'hA5};
    if_a.cmd_valid = 1'b1;
    tick();
    if_a.cmd_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      n_cmp++; if (ss_n_a !== 1'b0) begin n_fail++; $display("FAIL wr_ss_n bit%0d: got %b want 0", i, ss_n_a); end
      n_cmp++; if (mosi_a !== exp_bits[i][0]) begin n_fail++; $display("FAIL wr_mosi bit%0d: got %b want %0d", i, mosi_a, exp_bits[i]); end
      tick();
    end
    n_cmp++; if (ss_n_a !== 1'b1) begin n_fail++; $display("FAIL wr_gap_ss_n: got %b want 1", ss_n_a); end
    n_cmp++; if (if_a.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wr_gap_ready: got %b want 0", if_a.cmd_ready); end
    n_cmp++; if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL wr_gap_busy: got %b want 1", if_a.busy); end
    tick();
    n_cmp++; if (if_a.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_after: got %b want 1", if_a.cmd_ready); end
    n_cmp++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after: got %b want 0", if_a.busy); end
    n_cmp++; if (rv_a - rv0 !== 0) begin n_fail++; $display("FAIL wr_no_rd_valid: got %0d pulses want 0", rv_a - rv0); end
    n_cmp++; if (ss_low_a - ss0 !== 11) begin n_fail++; $display("FAIL wr_ss_low_len: got %0d want 11", ss_low_a - ss0); end
  endtask

  task automatic test_read_data();
    logic [7:0] reply = 8'hC3;
    int rv0 = rv_a;
    int ss0 = ss_low_a;
    if_a.cmd_data  = {CMD_RD_DATA, 8'h00};
    if_a.cmd_valid = 1'b1;
    tick();
    if_a.cmd_valid = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      miso_a = (c >= 14) ? reply[21 - c] : 1'b0;
      n_cmp++; if (ss_n_a !== 1'b0) begin n_fail++; $display("FAIL rd_ss_n c%0d: got %b want 0", c, ss_n_a); end
      n_cmp++; if (mosi_a !== (c <= 3)) begin n_fail++; $display("FAIL rd_mosi c%0d: got %b want %b", c, mosi_a, c <= 3); end
      n_cmp++; if (if_a.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_early c%0d: got %b want 0", c, if_a.rd_valid); end
      tick();
    end
    miso_a = 1'b0;
    n_cmp++; if (ss_n_a !== 1'b1) begin n_fail++; $display("FAIL rd_end_ss_n: got %b want 1", ss_n_a); end
    n_cmp++; if (if_a.rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid_T22: got %b want 1", if_a.rd_valid); end
    n_cmp++; if (if_a.rd_data !== 8'hC3) begin n_fail++; $display("FAIL rd_data: got %h want c3", if_a.rd_data); end
    tick();
    n_cmp++; if (if_a.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_drop: got %b want 0", if_a.rd_valid); end
    n_cmp++; if (if_a.rd_data !== 8'hC3) begin n_fail++; $display("FAIL rd_data_hold: got %h want c3", if_a.rd_data); end
    n_cmp++; if (if_a.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready_after: got %b want 1", if_a.cmd_ready); end
    n_cmp++; if (rv_a - rv0 !== 1) begin n_fail++; $display("FAIL rd_pulse_count: got %0d want 1", rv_a - rv0); end
    n_cmp++; if (ss_low_a - ss0 !== 21) begin n_fail++; $display("FAIL rd_ss_low_len: got %0d want 21", ss_low_a - ss0); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] frames [4];
    logic [7:0]  reply = 8'h96;
    logic        exp_ss;
    logic        accept_now;
    int          idx = 0;
    int          hs0 = hs_a;
    int          rv0 = rv_a;
    frames[0] = {CMD_WR_ADDR, 8'h3C};
    frames[1] = {CMD_WR_DATA, 8'h81};
    frames[2] = {CMD_RD_ADDR, 8'h42};
    frames[3] = {CMD_RD_DATA, 8'hFF};
    if_a.cmd_data  = frames[0];
    if_a.cmd_valid = 1'b1;
    tick();
    idx = 1;
    // Next frame is presented immediately; it must not disturb the one in flight.
    if_a.cmd_data = frames[1];
    // Accepts at c=0,13,26,39: SS_n high in each GAP cycle and the idle cycle that follows.
    for (int c = 1; c <= 62; c++) begin
      exp_ss = (c == 12 || c == 13 || c == 25 || c == 26 || c == 38 || c == 39 || c >= 61);
      miso_a = (c >= 53 && c <= 60) ? reply[60 - c] : 1'b0;
      n_cmp++; if (ss_n_a !== exp_ss) begin n_fail++; $display("FAIL b2b_ss_n c%0d: got %b want %b", c, ss_n_a, exp_ss); end
      if (c == 3) begin
        n_cmp++; if (mosi_a !== 1'b0) begin n_fail++; $display("FAIL b2b_mosi_f0b8: got %b want 0", mosi_a); end
      end
      if (c == 16) begin
        n_cmp++; if (mosi_a !== 1'b1) begin n_fail++; $display("FAIL b2b_mosi_f1b8: got %b want 1", mosi_a); end
      end
      if (c >= 40 && c <= 42) begin
        n_cmp++; if (mosi_a !== 1'b1) begin n_fail++; $display("FAIL b2b_mosi_f3 c%0d: got %b want 1", c, mosi_a); end
      end
      if (c == 61) begin
        n_cmp++; if (if_a.rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_valid: got %b want 1", if_a.rd_valid); end
        n_cmp++; if (if_a.rd_data !== 8'h96) begin n_fail++; $display("FAIL b2b_rd_data: got %h want 96", if_a.rd_data); end
      end
      accept_now = if_a.cmd_valid && if_a.cmd_ready;
      tick();
      if (accept_now) begin
        idx++;
        if (idx < 4) if_a.cmd_data = frames[idx];
        else if_a.cmd_valid = 1'b0;
      end
    end
    if_a.cmd_valid = 1'b0;
    miso_a = 1'b0;
    n_cmp++; if (hs_a - hs0 !== 4) begin n_fail++; $display("FAIL b2b_handshakes: got %0d want 4", hs_a - hs0); end
    n_cmp++; if (rv_a - rv0 !== 1) begin n_fail++; $display("FAIL b2b_rd_pulses: got %0d want 1", rv_a - rv0); end
    n_cmp++; if (if_a.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b want 1", if_a.cmd_ready); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] reply1 = 8'hA5;
    logic [7:0] reply2 = 8'h3C;
    int rv0 = rv_a;
    if_a.cmd_data  = {CMD_RD_DATA, 8'h10};
    if_a.cmd_valid = 1'b1;
    tick();
    if_a.cmd_valid = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      miso_a = (c >= 14) ? reply1[21 - c] : 1'b0;
      if (c == 18) rst_n = 1'b0;  // 5th capture cycle
      tick();
    end
    miso_a = 1'b0;
    n_cmp++; if (ss_n_a !== 1'b1) begin n_fail++; $display("FAIL abort_ss_n: got %b want 1", ss_n_a); end
    n_cmp++; if (mosi_a !== 1'b0) begin n_fail++; $display("FAIL abort_mosi: got %b want 0", mosi_a); end
    n_cmp++; if (if_a.rd_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rd_valid: got %b want 0", if_a.rd_valid); end
    n_cmp++; if (if_a.rd_data !== 8'h00) begin n_fail++; $display("FAIL abort_rd_data: got %h want 00", if_a.rd_data); end
    n_cmp++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", if_a.busy); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (rv_a - rv0 !== 0) begin n_fail++; $display("FAIL abort_no_pulse: got %0d want 0", rv_a - rv0); end
    n_cmp++; if (if_a.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", if_a.cmd_ready); end
    if_a.cmd_data  = {CMD_RD_DATA, 8'h10};
    if_a.cmd_valid = 1'b1;
    tick();
    if_a.cmd_valid = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      miso_a = (c >= 14) ? reply2[21 - c] : 1'b0;
      tick();
    end
    miso_a = 1'b0;
    n_cmp++; if (if_a.rd_valid !== 1'b1) begin n_fail++; $display("FAIL reread_rd_valid: got %b want 1", if_a.rd_valid); end
    n_cmp++; if (if_a.rd_data !== 8'h3C) begin n_fail++; $display("FAIL reread_rd_data: got %h want 3c", if_a.rd_data); end
    tick();
  endtask

  task automatic test_rd_wait0();
    logic [7:0] reply = 8'h5A;
    int ss0 = ss_low_b;
    int rv0 = rv_b;
    if_b.cmd_data  = {CMD_RD_DATA, 8'h53};
    if_b.cmd_valid = 1'b1;
    tick();
    if_b.cmd_valid = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      miso_b = (c >= 12) ? reply[19 - c] : 1'b0;
      n_cmp++; if (ss_n_b !== 1'b0) begin n_fail++; $display("FAIL w0_ss_n c%0d: got %b want 0", c, ss_n_b); end
      tick();
    end
    miso_b = 1'b0;
    n_cmp++; if (ss_n_b !== 1'b1) begin n_fail++; $display("FAIL w0_end_ss_n: got %b want 1", ss_n_b); end
    n_cmp++; if (if_b.rd_valid !== 1'b1) begin n_fail++; $display("FAIL w0_rd_valid: got %b want 1", if_b.rd_valid); end
    n_cmp++; if (if_b.rd_data !== 8'h5A) begin n_fail++; $display("FAIL w0_rd_data: got %h want 5a", if_b.rd_data); end
    tick();
    n_cmp++; if (ss_low_b - ss0 !== 19) begin n_fail++; $display("FAIL w0_ss_low_len: got %0d want 19", ss_low_b - ss0); end
    n_cmp++; if (rv_b - rv0 !== 1) begin n_fail++; $display("FAIL w0_pulses: got %0d want 1", rv_b - rv0); end
    n_cmp++; if (if_b.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL w0_ready: got %b want 1", if_b.cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_read_data();
    test_back_to_back();
    test_reset_mid_read();
    test_rd_wait0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
